regwb_queue: RTL and testbench

Register write-back queue for the single-cycle CPU datapath. It accepts destination-register writes from the ALU result path and the load path over valid/ready handshakes and buffers them in an in-order FIFO. It drains one entry per cycle onto the register file write port (`WriteRegister`/`RegWrite`/`WriteData`). It also exposes a forwarding lookup so the read side can pick up the newest value for a register whose write has not yet landed.

---
 rtl/regwb_queue.sv | 122 ++++++++++++
 tb/tb_regwb_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/regwb_queue.sv
// Register write-back queue: accepts ALU and load writes into an in-order FIFO,
// drains one entry per cycle to the register file port and forwards pending values.
module regwb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [AW-1:0]          alu_rd,
  input  logic [DW-1:0]          alu_data,
  output logic                   alu_ready,
  input  logic                   ld_valid,
  input  logic [AW-1:0]          ld_rd,
  input  logic [DW-1:0]          ld_data,
  output logic                   ld_ready,
  input  logic                   stall,
  output logic [AW-1:0]          WriteRegister,
  output logic                   RegWrite,
  output logic [DW-1:0]          WriteData,
  input  logic [AW-1:0]          ra,
  input  logic [AW-1:0]          rb,
  output logic                   fwd_a_hit,
  output logic [DW-1:0]          fwd_a_data,
  output logic                   fwd_b_hit,
  output logic [DW-1:0]          fwd_b_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] rd_mem   [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          alu_acc;
  logic          ld_acc;
  logic          drain;
  logic [CW-1:0] n_acc;
  logic [PW-1:0] ld_slot;

  // Readiness looks only at registered occupancy; a same-edge drain never frees a slot.
  assign alu_ready = (count < CW'(DEPTH));
  assign ld_ready  = (count <= CW'(DEPTH - 2)) ||
                     ((count == CW'(DEPTH - 1)) && !alu_valid);

  assign alu_acc = alu_valid && alu_ready;
  assign ld_acc  = ld_valid && ld_ready;
  assign drain   = (count != '0) && !stall;
  assign n_acc   = CW'(alu_acc) + CW'(ld_acc);
  // When both sources are accepted the load lands behind the ALU entry.
  assign ld_slot = tail + PW'(alu_acc);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      tail     <= tail + PW'(n_acc);
      head     <= head + PW'(drain);
      count    <= count + n_acc - CW'(drain);
      RegWrite <= drain;
      if (drain) begin
        WriteRegister <= rd_mem[head];
        WriteData     <= data_mem[head];
      end
    end
  end

  // NOTE: the entry storage has no reset; occupancy and pointers alone decide
  // which slots are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (alu_acc) begin
      rd_mem[tail]   <= alu_rd;
      data_mem[tail] <= alu_data;
    end
    if (ld_acc) begin
      rd_mem[ld_slot]   <= ld_rd;
      data_mem[ld_slot] <= ld_data;
    end
  end

  // Forwarding: scan from oldest to newest so the newest match wins; the
  // output stage is the oldest candidate of all.
  // NOTE: every output gets a default at the top of the block, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    fwd_a_hit  = 1'b0;
    fwd_a_data = '0;
    fwd_b_hit  = 1'b0;
    fwd_b_data = '0;
    if (RegWrite && (WriteRegister == ra)) begin
      fwd_a_hit  = 1'b1;
      fwd_a_data = WriteData;
    end
    if (RegWrite && (WriteRegister == rb)) begin
      fwd_b_hit  = 1'b1;
      fwd_b_data = WriteData;
    end
    for (int j = 0; j < DEPTH; j++) begin
      if (CW'(j) < count) begin
        if (rd_mem[head + PW'(j)] == ra) begin
          fwd_a_hit  = 1'b1;
          fwd_a_data = data_mem[head + PW'(j)];
        end
        if (rd_mem[head + PW'(j)] == rb) begin
          fwd_b_hit  = 1'b1;
          fwd_b_data = data_mem[head + PW'(j)];
        end
      end
    end
  end

endmodule

// File: tb/tb_regwb_queue.sv
// Directed plus short random bench for regwb_queue; a queue of pending writes
// serves as scoreboard for drain order, occupancy, readiness and forwarding.
module tb_regwb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_rd;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          stall;
  logic [AW-1:0] WriteRegister;
  logic          RegWrite;
  logic [DW-1:0] WriteData;
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic          fwd_a_hit;
  logic [DW-1:0] fwd_a_data;
  logic          fwd_b_hit;
  logic [DW-1:0] fwd_b_data;
  logic [$clog2(DEPTH):0] count;

  regwb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .stall(stall),
    .WriteRegister(WriteRegister), .RegWrite(RegWrite), .WriteData(WriteData),
    .ra(ra), .rb(rb),
    .fwd_a_hit(fwd_a_hit), .fwd_a_data(fwd_a_data),
    .fwd_b_hit(fwd_b_hit), .fwd_b_data(fwd_b_data),
    .count(count)
  );

  always #5 clk = ~clk;

  entry_t        sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic          exp_rw = 1'b0;
  logic [AW-1:0] last_rd = '0;
  logic [DW-1:0] last_data = '0;
  logic          alu_acc_last = 1'b0;
  logic          ld_acc_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Newest pending write wins; the output stage is the oldest candidate.
  task automatic fwd_model(input logic [AW-1:0] r, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (exp_rw && last_rd == r) begin
      hit = 1'b1;
      d   = last_data;
    end
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].rd == r) begin
        hit = 1'b1;
        d   = sb[i].data;
      end
    end
  endtask

  // One clock: check readiness before the edge, update the model, check after the edge.
  task automatic tick();
    int            m_cnt;
    logic          exp_ar, exp_lr, acc_a, acc_l, drn, h;
    logic [DW-1:0] d;
    entry_t        e;
    #1;
    m_cnt  = sb.size();
    exp_ar = (m_cnt < DEPTH);
    exp_lr = (m_cnt <= DEPTH - 2) || (m_cnt == DEPTH - 1 && !alu_valid);
    if (!rst) begin
      check("alu_ready", alu_ready, exp_ar);
      check("ld_ready", ld_ready, exp_lr);
    end
    acc_a = !rst && alu_valid && exp_ar;
    acc_l = !rst && ld_valid && exp_lr;
    drn   = !rst && (m_cnt > 0) && !stall;
    if (drn) begin
      e         = sb.pop_front();
      last_rd   = e.rd;
      last_data = e.data;
    end
    if (acc_a) sb.push_back('{rd: alu_rd, data: alu_data});
    if (acc_l) sb.push_back('{rd: ld_rd, data: ld_data});
    if (rst) begin
      sb.delete();
      last_rd   = '0;
      last_data = '0;
    end
    exp_rw       = drn;
    alu_acc_last = acc_a;
    ld_acc_last  = acc_l;
    @(posedge clk);
    #1;
    check("count", count, sb.size());
    check("RegWrite", RegWrite, exp_rw);
    check("WriteRegister", WriteRegister, last_rd);
    check("WriteData", WriteData, last_data);
    fwd_model(ra, h, d);
    check("fwd_a_hit", fwd_a_hit, h);
    check("fwd_a_data", fwd_a_data, d);
    fwd_model(rb, h, d);
    check("fwd_b_hit", fwd_b_hit, h);
    check("fwd_b_data", fwd_b_data, d);
  endtask

  task automatic idle(input int n);
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present an ALU write and hold it until accepted, within a bounded number of cycles.
  task automatic send_alu(input logic [AW-1:0] r, input logic [DW-1:0] d);
    alu_valid = 1'b1;
    alu_rd    = r;
    alu_data  = d;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (alu_acc_last) break;
    end
    check("alu_accept_timeout", alu_acc_last, 1'b1);
    alu_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; ld_valid = 1'b0; stall = 1'b0;
    alu_rd = '0; alu_data = '0; ld_rd = '0; ld_data = '0; ra = '0; rb = '0;
    tick();
    tick();
    rst = 1'b0;
    ra = 5'd2; rb = 5'd3;
    idle(1);

    // Single write: one pulse one cycle after acceptance, occupancy back to 0.
    send_alu(5'd2, 32'h0000_0010);
    idle(2);

    // Dual accept: ALU entry is older than the load entry.
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA;
    ld_valid  = 1'b1; ld_rd  = 5'd3; ld_data  = 32'hB;
    tick();
    check("dual_both_accepted", {alu_acc_last, ld_acc_last}, 2'b11);
    idle(3);

    // Fill under stall, then a fifth request held while full.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) send_alu(AW'(i), 32'h1000 + i);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h55;
    tick();
    tick();
    stall = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (alu_acc_last) break;
    end
    check("held_fifth_accepted", alu_acc_last, 1'b1);
    idle(6);

    // Forward priority: the younger of two writes to r4 wins.
    stall = 1'b1; ra = 5'd4; rb = 5'd1;
    send_alu(5'd4, 32'h100);
    send_alu(5'd4, 32'h200);
    idle(1);
    check("fwd_a_newest", fwd_a_data, 32'h200);
    stall = 1'b0;
    idle(4);

    // Near-full arbitration: ALU wins the last slot, the load waits.
    stall = 1'b1; ra = 5'd9; rb = 5'd10;
    for (int i = 0; i < 3; i++) send_alu(AW'(6 + i), 32'h600 + i);
    alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h900;
    ld_valid  = 1'b1; ld_rd  = 5'd10; ld_data  = 32'hA00;
    tick();
    check("near_full_split", {alu_acc_last, ld_acc_last}, 2'b10);
    alu_valid = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ld_acc_last) break;
    end
    check("held_load_accepted", ld_acc_last, 1'b1);
    idle(6);

    // Reset mid-drain: queued entries vanish, requests during reset are ignored.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) send_alu(AW'(20 + i), 32'h2000 + i);
    stall = 1'b0;
    tick();
    rst = 1'b1; alu_valid = 1'b1; alu_rd = 5'd30; alu_data = 32'hDEAD;
    tick();
    rst = 1'b0;
    idle(3);
    send_alu(5'd11, 32'hBEEF);
    idle(2);

    // Short random phase exercising wrap-around, stalls and mixed traffic.
    for (int i = 0; i < 60; i++) begin
      alu_valid = 1'($urandom_range(0, 1));
      alu_rd    = AW'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_valid  = 1'($urandom_range(0, 1));
      ld_rd     = AW'($urandom_range(0, 7));
      ld_data   = $urandom;
      stall     = ($urandom_range(0, 3) == 0);
      ra        = AW'($urandom_range(0, 7));
      rb        = AW'($urandom_range(0, 7));
      tick();
    end
    stall = 1'b0;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
